ctrl: RTL and testbench
=======================

Name: ctrl

Overview:
- Main decoder/controller of the rysyCore RV32I core.
- Decodes opcode[6:2], func3 and func7 into datapath selects: ALU op, immediate type, ALU operand muxes, rd mux, register-file write, PC/memory address select, instruction-register select, load/store type, data-memory write enable.
- Almost all logic is combinational. The one state element is a load_phase flop that stretches LOAD to two cycles.

Parameters:
none

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous active-low reset
opcode  in  5  instruction bits [6:2]
func3  in  3  instruction bits [14:12]
func7  in  7  instruction bits [31:25]
b  in  1  branch-condition result from cmp (1 = condition true)
imm_type  out  3  imm_mux select
inst_sel  out  2  inst_mgmt select
reg_wr  out  1  reg_file write enable
alu_op  out  4  alu operation
cmp_op  out  3  cmp operation
pc_sel  out  2  next-PC select (mem_addr_sel)
mem_sel  out  1  memory address source (mem_addr_sel)
rd_sel  out  2  rd_mux select
alu1_sel  out  1  alu1_mux select
alu2_sel  out  1  alu2_mux select
sel_type  out  3  load/store width select
we  out  1  data memory write enable

Behaviour:
- Opcodes: LOAD 00000, OP_IMM 00100, AUIPC 00101, STORE 01000, OP 01100, LUI 01101, BRANCH 11000, JALR 11001, JAL 11011. Any other value is "other".
- alu_op encodings: ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- alu_op for OP and OP_IMM, by func3:
  - 000: SUB only if opcode=OP and func7=0100000; otherwise ADD.
  - 010 SLT; 011 SLTU; 100 XOR; 110 OR; 111 AND; 001 SLL.
  - 101: SRA if func7=0100000, else SRL.
- alu_op for all other opcodes: ADD.
- imm_type: LUI/AUIPC 001 (U); JAL 010 (J); STORE 011 (S); OP_IMM/LOAD/JALR 100 (I); BRANCH 101 (B); otherwise 000.
- alu1_sel: 1 (PC) for JAL, AUIPC, BRANCH; else 0 (rs1).
- alu2_sel: 0 (rs2) only for OP; else 1 (immediate), including "other" opcodes.
- rd_sel:
  - 00 immediate (LUI)
  - 01 PC+4 (JAL, JALR)
  - 10 ALU result (OP, OP_IMM, AUIPC, and default)
  - 11 memory data (LOAD)
- cmp_op: func3 when opcode=BRANCH, else 010 (no compare).
- Branch taken = (opcode=BRANCH and b=1).
- pc_sel:
  - 11 hold: LOAD phase 0
  - 10 JALR target: JALR
  - 01 ALU target: JAL or branch taken
  - 00 PC+4: all other cases
- inst_sel:
  - 10 hold instruction: LOAD phase 0
  - 01 insert NOP/flush: JAL, JALR, or branch taken
  - 00 pass fetched instruction: all other cases
- mem_sel: 1 (ALU address) for STORE and for LOAD phase 0; else 0 (PC fetch address).
- we: 1 only for STORE.
- sel_type: func3 for LOAD/STORE; else 010 (word).
- reg_wr:
  - 0 for STORE, BRANCH, "other", and LOAD phase 0.
  - 1 for OP, OP_IMM, LUI, AUIPC, JAL, JALR, and LOAD phase 1.
- load_phase register, updated on rising clk:
  - opcode=LOAD and load_phase=0: next is 1.
  - Any other case: next is 0.
  - A LOAD therefore occupies exactly two cycles. Consecutive LOADs each take two cycles.
- Reset: rst=0 asynchronously clears load_phase to 0. While rst=0, reg_wr=0, we=0, pc_sel=00, inst_sel=01. All other outputs keep their combinational decode.
- Latency: outputs settle combinationally in the same cycle as opcode/func3/func7/b change. Only load_phase adds state.
- Outputs are never X once rst has been asserted at least once.

Test Plan:
- OP, func3=000: func7=0100000 -> alu_op 0001; func7=0000000 -> 0000. OP_IMM, func3=000, func7=0100000 -> alu_op 0000. OP func3=010 -> 1000; 100 -> 0010; 001 -> 0101; 101 with func7=0000000 -> 0110, with 0100000 -> 0111. STORE -> 0000; JALR -> 0000.
- LUI -> imm_type 001; OP_IMM -> 100; STORE -> 011, we=1. JAL -> alu1_sel 1; LOAD -> alu1_sel 0.
- OP -> alu2_sel 0; opcode 10101 -> 1; OP_IMM -> 1; OP -> 0.
- After reset, LOAD held for 2 clocks:
  - Cycle 1: reg_wr 0, pc_sel 11, inst_sel 10, mem_sel 1.
  - Cycle 2: reg_wr 1, rd_sel 11, pc_sel 00.
  - STORE -> reg_wr 0; OP_IMM -> reg_wr 1, rd_sel 10; JAL -> rd_sel 01.
- BRANCH func3=001: b=0 -> pc_sel 00, inst_sel 00, cmp_op 001; b=1 -> pc_sel 01, inst_sel 01, reg_wr 0.
- Assert rst=0 during LOAD phase 1 -> load_phase 0 immediately, reg_wr 0, we 0; after release with LOAD present, sequence restarts at phase 0.

Source files
------------

// File: rtl/ctrl.sv
// rtl/ctrl.sv - rysyCore RV32I main decoder with two-cycle LOAD sequencing
module ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       b,
  output logic [2:0] imm_type,
  output logic [1:0] inst_sel,
  output logic       reg_wr,
  output logic [3:0] alu_op,
  output logic [2:0] cmp_op,
  output logic [1:0] pc_sel,
  output logic       mem_sel,
  output logic [1:0] rd_sel,
  output logic       alu1_sel,
  output logic       alu2_sel,
  output logic [2:0] sel_type,
  output logic       we
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  logic load_phase_q;
  logic load_phase_d;
  logic is_load;
  logic is_store;
  logic is_op;
  logic is_op_imm;
  logic is_branch;
  logic is_jal;
  logic is_jalr;
  logic taken;
  logic load_wait;

  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign taken     = is_branch && b;
  // First LOAD cycle: the bus is lent to the data access, so fetch stalls.
  assign load_wait = is_load && !load_phase_q;

  // A LOAD always advances to phase 1; anything else (including phase 1) returns to 0.
  always_comb begin
    load_phase_d = load_wait;
  end

  // The only state in the controller: which half of a LOAD we are in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_phase_q <= 1'b0;
    end else begin
      load_phase_q <= load_phase_d;
    end
  end

  // ALU operation: func3/func7 decode for arithmetic opcodes, ADD for address math.
  always_comb begin
    alu_op = ALU_ADD;
    if (is_op || is_op_imm) begin
      case (func3)
        3'b000:  alu_op = (is_op && func7 == F7_ALT) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = (func7 == F7_ALT) ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end
  end

  // Datapath selects; reset only silences the state-changing controls.
  always_comb begin
    imm_type = 3'b000;
    rd_sel   = 2'b10;
    reg_wr   = 1'b0;
    case (opcode)
      OPC_LUI:    begin imm_type = 3'b001; rd_sel = 2'b00; reg_wr = 1'b1; end
      OPC_AUIPC:  begin imm_type = 3'b001; reg_wr = 1'b1; end
      OPC_JAL:    begin imm_type = 3'b010; rd_sel = 2'b01; reg_wr = 1'b1; end
      OPC_JALR:   begin imm_type = 3'b100; rd_sel = 2'b01; reg_wr = 1'b1; end
      OPC_STORE:  imm_type = 3'b011;
      OPC_OP_IMM: begin imm_type = 3'b100; reg_wr = 1'b1; end
      OPC_OP:     reg_wr = 1'b1;
      OPC_LOAD:   begin imm_type = 3'b100; rd_sel = 2'b11; reg_wr = load_phase_q; end
      OPC_BRANCH: imm_type = 3'b101;
      default:    ;
    endcase

    alu1_sel = is_jal || (opcode == OPC_AUIPC) || is_branch;
    alu2_sel = !is_op;
    cmp_op   = is_branch ? func3 : 3'b010;
    sel_type = (is_load || is_store) ? func3 : 3'b010;
    mem_sel  = is_store || load_wait;
    we       = is_store;

    if (load_wait)          pc_sel = 2'b11;
    else if (is_jalr)       pc_sel = 2'b10;
    else if (is_jal || taken) pc_sel = 2'b01;
    else                    pc_sel = 2'b00;

    if (load_wait)                     inst_sel = 2'b10;
    else if (is_jal || is_jalr || taken) inst_sel = 2'b01;
    else                               inst_sel = 2'b00;

    if (!rst) begin
      reg_wr   = 1'b0;
      we       = 1'b0;
      pc_sel   = 2'b00;
      inst_sel = 2'b01;
    end
  end

endmodule

// File: tb/tb_ctrl.sv
// tb/tb_ctrl.sv - directed scoreboard bench for the ctrl decoder
module tb_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       b;
  logic [2:0] imm_type;
  logic [1:0] inst_sel;
  logic       reg_wr;
  logic [3:0] alu_op;
  logic [2:0] cmp_op;
  logic [1:0] pc_sel;
  logic       mem_sel;
  logic [1:0] rd_sel;
  logic       alu1_sel;
  logic       alu2_sel;
  logic [2:0] sel_type;
  logic       we;

  int checks = 0;
  int errors = 0;

  typedef enum int {F_IMM, F_INST, F_REGWR, F_ALU, F_CMP, F_PC, F_MEM, F_RD,
                    F_A1, F_A2, F_SEL, F_WE} field_e;

  typedef struct {
    string      tag;
    field_e     fld;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];

  ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .b(b),
    .imm_type(imm_type), .inst_sel(inst_sel), .reg_wr(reg_wr), .alu_op(alu_op),
    .cmp_op(cmp_op), .pc_sel(pc_sel), .mem_sel(mem_sel), .rd_sel(rd_sel),
    .alu1_sel(alu1_sel), .alu2_sel(alu2_sel), .sel_type(sel_type), .we(we)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] observe(field_e f);
    case (f)
      F_IMM:   return {1'b0, imm_type};
      F_INST:  return {2'b00, inst_sel};
      F_REGWR: return {3'b000, reg_wr};
      F_ALU:   return alu_op;
      F_CMP:   return {1'b0, cmp_op};
      F_PC:    return {2'b00, pc_sel};
      F_MEM:   return {3'b000, mem_sel};
      F_RD:    return {2'b00, rd_sel};
      F_A1:    return {3'b000, alu1_sel};
      F_A2:    return {3'b000, alu2_sel};
      F_SEL:   return {1'b0, sel_type};
      default: return {3'b000, we};
    endcase
  endfunction

  // Apply an instruction just after a falling edge so it is stable for the next rising edge.
  task automatic drive(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic bb);
    @(negedge clk);
    opcode = op;
    func3  = f3;
    func7  = f7;
    b      = bb;
  endtask

  task automatic expect_f(input string tag, input field_e f, input logic [3:0] v);
    sb.push_back('{tag, f, v});
  endtask

  // Let the combinational decode settle, then drain the scoreboard against the outputs.
  task automatic check_all();
    exp_t e;
    logic [3:0] obs;
    #2;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.fld);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    rst = 1'b0; opcode = 5'b01000; func3 = 3'b010; func7 = 7'd0; b = 1'b0;
    expect_f("rst_reg_wr", F_REGWR, 4'd0);
    expect_f("rst_we", F_WE, 4'd0);
    expect_f("rst_pc_sel", F_PC, 4'd0);
    expect_f("rst_inst_sel", F_INST, 4'd1);
    expect_f("rst_imm_store", F_IMM, 4'd3);
    expect_f("rst_mem_sel", F_MEM, 4'd1);
    check_all();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // ALU decode
    drive(5'b01100, 3'b000, 7'b0100000, 1'b0); expect_f("op_sub", F_ALU, 4'b0001); expect_f("op_alu2", F_A2, 4'd0); check_all();
    drive(5'b01100, 3'b000, 7'b0000000, 1'b0); expect_f("op_add", F_ALU, 4'b0000); check_all();
    drive(5'b00100, 3'b000, 7'b0100000, 1'b0); expect_f("opimm_add", F_ALU, 4'b0000); expect_f("opimm_imm", F_IMM, 4'b0100);
    expect_f("opimm_alu2", F_A2, 4'd1); expect_f("opimm_reg_wr", F_REGWR, 4'd1); expect_f("opimm_rd", F_RD, 4'b0010); check_all();
    drive(5'b01100, 3'b010, 7'b0000000, 1'b0); expect_f("op_slt", F_ALU, 4'b1000); check_all();
    drive(5'b01100, 3'b100, 7'b0000000, 1'b0); expect_f("op_xor", F_ALU, 4'b0010); check_all();
    drive(5'b01100, 3'b001, 7'b0000000, 1'b0); expect_f("op_sll", F_ALU, 4'b0101); check_all();
    drive(5'b01100, 3'b101, 7'b0000000, 1'b0); expect_f("op_srl", F_ALU, 4'b0110); check_all();
    drive(5'b01100, 3'b101, 7'b0100000, 1'b0); expect_f("op_sra", F_ALU, 4'b0111); expect_f("op_alu2_b", F_A2, 4'd0); check_all();
    drive(5'b01100, 3'b011, 7'b0000000, 1'b0); expect_f("op_sltu", F_ALU, 4'b1001); check_all();
    drive(5'b01100, 3'b110, 7'b0000000, 1'b0); expect_f("op_or", F_ALU, 4'b0011); check_all();
    drive(5'b01100, 3'b111, 7'b0000000, 1'b0); expect_f("op_and", F_ALU, 4'b0100); check_all();

    // Store, LUI, jumps, unknown opcode
    drive(5'b01000, 3'b000, 7'b0100000, 1'b0); expect_f("st_alu", F_ALU, 4'b0000); expect_f("st_imm", F_IMM, 4'b0011);
    expect_f("st_we", F_WE, 4'd1); expect_f("st_reg_wr", F_REGWR, 4'd0); expect_f("st_sel", F_SEL, 4'b0000); expect_f("st_mem", F_MEM, 4'd1); check_all();
    drive(5'b01101, 3'b000, 7'b0000000, 1'b0); expect_f("lui_imm", F_IMM, 4'b0001); expect_f("lui_rd", F_RD, 4'b0000); check_all();
    drive(5'b11011, 3'b000, 7'b0000000, 1'b0); expect_f("jal_a1", F_A1, 4'd1); expect_f("jal_rd", F_RD, 4'b0001);
    expect_f("jal_pc", F_PC, 4'b0001); expect_f("jal_inst", F_INST, 4'b0001); expect_f("jal_imm", F_IMM, 4'b0010); check_all();
    drive(5'b11001, 3'b000, 7'b0100000, 1'b0); expect_f("jalr_alu", F_ALU, 4'b0000); expect_f("jalr_pc", F_PC, 4'b0010);
    expect_f("jalr_a1", F_A1, 4'd0); expect_f("jalr_sel", F_SEL, 4'b0010); check_all();
    drive(5'b10101, 3'b101, 7'b0100000, 1'b0); expect_f("oth_alu2", F_A2, 4'd1); expect_f("oth_imm", F_IMM, 4'b0000);
    expect_f("oth_reg_wr", F_REGWR, 4'd0); expect_f("oth_alu", F_ALU, 4'b0000); expect_f("oth_cmp", F_CMP, 4'b0010); check_all();

    // Branch not taken / taken
    drive(5'b11000, 3'b001, 7'b0000000, 1'b0); expect_f("br0_pc", F_PC, 4'b0000); expect_f("br0_inst", F_INST, 4'b0000);
    expect_f("br0_cmp", F_CMP, 4'b0001); expect_f("br0_imm", F_IMM, 4'b0101); check_all();
    drive(5'b11000, 3'b001, 7'b0000000, 1'b1); expect_f("br1_pc", F_PC, 4'b0001); expect_f("br1_inst", F_INST, 4'b0001);
    expect_f("br1_reg_wr", F_REGWR, 4'd0); expect_f("br1_a1", F_A1, 4'd1); check_all();

    // Two back-to-back LOADs, each two cycles long
    drive(5'b00000, 3'b100, 7'b0000000, 1'b0); expect_f("ld1_reg_wr", F_REGWR, 4'd0); expect_f("ld1_pc", F_PC, 4'b0011);
    expect_f("ld1_inst", F_INST, 4'b0010); expect_f("ld1_mem", F_MEM, 4'd1); expect_f("ld1_a1", F_A1, 4'd0); expect_f("ld1_sel", F_SEL, 4'b0100); check_all();
    drive(5'b00000, 3'b100, 7'b0000000, 1'b0); expect_f("ld2_reg_wr", F_REGWR, 4'd1); expect_f("ld2_rd", F_RD, 4'b0011);
    expect_f("ld2_pc", F_PC, 4'b0000); expect_f("ld2_inst", F_INST, 4'b0000); expect_f("ld2_mem", F_MEM, 4'd0); check_all();
    drive(5'b00000, 3'b100, 7'b0000000, 1'b0); expect_f("ld3_pc", F_PC, 4'b0011); expect_f("ld3_reg_wr", F_REGWR, 4'd0); check_all();
    drive(5'b00000, 3'b100, 7'b0000000, 1'b0); expect_f("ld4_reg_wr", F_REGWR, 4'd1); check_all();

    // Reset asserted during LOAD phase 1
    drive(5'b00000, 3'b010, 7'b0000000, 1'b0); expect_f("ld5_pc", F_PC, 4'b0011); check_all();
    @(negedge clk);
    #1 rst = 1'b0;
    expect_f("rstld_reg_wr", F_REGWR, 4'd0); expect_f("rstld_we", F_WE, 4'd0); expect_f("rstld_pc", F_PC, 4'b0000);
    expect_f("rstld_inst", F_INST, 4'b0001); expect_f("rstld_mem", F_MEM, 4'd1); check_all();
    @(negedge clk);
    rst = 1'b1;
    expect_f("rel_pc", F_PC, 4'b0011); expect_f("rel_inst", F_INST, 4'b0010); expect_f("rel_reg_wr", F_REGWR, 4'd0); check_all();
    @(negedge clk);
    expect_f("rel2_reg_wr", F_REGWR, 4'd1); expect_f("rel2_pc", F_PC, 4'b0000); check_all();

    // OP after LOAD resumes normal decode
    drive(5'b01100, 3'b000, 7'b0000000, 1'b0); expect_f("op_end_alu2", F_A2, 4'd0); expect_f("op_end_pc", F_PC, 4'b0000); check_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
